// File: rtl/i2si_bist_pkg.sv
// Shared encodings for the I2S input BIST pattern generator.
package i2si_bist_pkg;

  typedef enum logic [1:0] {
    BIST_SAW    = 2'd0,
    BIST_TRI    = 2'd1,
    BIST_SQUARE = 2'd2,
    BIST_CONST  = 2'd3
  } bist_mode_t;

  // Triangle direction encoding
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Channel index width, never narrower than one bit
  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2si_bist_wave_core.sv
// Combinational next-sample / direction / hold-count for every pattern mode.
module i2si_bist_wave_core
  import i2si_bist_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int INC_W  = 8
) (
  input  bist_mode_t        mode_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              dir_i,
  input  logic [INC_W-1:0]  hold_i,
  input  logic [DATA_W-1:0] start_i,
  input  logic [DATA_W-1:0] limit_i,
  input  logic [INC_W-1:0]  inc_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              dir_o,
  output logic [INC_W-1:0]  hold_o
);

  // One guard bit so the triangle turn-around tests cannot wrap
  localparam int EW = DATA_W + 1;

  logic [EW-1:0]    inc_e;
  logic [EW-1:0]    up_sum;
  logic [EW-1:0]    lo_bound;
  logic [INC_W:0]   sq_period;
  logic [INC_W:0]   hold_p1;

  assign inc_e     = EW'(inc_i);
  assign up_sum    = {1'b0, sample_i} + inc_e;
  assign lo_bound  = {1'b0, start_i} + inc_e;
  assign sq_period = (inc_i == '0) ? (INC_W+1)'(1) : {1'b0, inc_i};
  assign hold_p1   = {1'b0, hold_i} + (INC_W+1)'(1);

  // Frame-boundary update rule selected by the latched mode
  always_comb begin
    sample_o = sample_i;
    dir_o    = dir_i;
    hold_o   = hold_i;
    unique case (mode_i)
      BIST_SAW: begin
        sample_o = (sample_i >= limit_i) ? start_i : up_sum[DATA_W-1:0];
      end
      BIST_TRI: begin
        if (limit_i <= start_i) begin
          // Degenerate range: pin to start
          sample_o = start_i;
          dir_o    = DIR_UP;
        end else if (dir_i == DIR_UP) begin
          if (up_sum >= {1'b0, limit_i}) begin
            sample_o = limit_i;
            dir_o    = DIR_DN;
          end else begin
            sample_o = up_sum[DATA_W-1:0];
          end
        end else begin
          if ({1'b0, sample_i} <= lo_bound) begin
            sample_o = start_i;
            dir_o    = DIR_UP;
          end else begin
            // sample > start+inc here, so inc fits in DATA_W bits
            sample_o = sample_i - inc_e[DATA_W-1:0];
          end
        end
      end
      BIST_SQUARE: begin
        if (hold_p1 >= sq_period) begin
          sample_o = (sample_i == start_i) ? limit_i : start_i;
          hold_o   = '0;
        end else begin
          hold_o   = hold_p1[INC_W-1:0];
        end
      end
      BIST_CONST: begin
        sample_o = start_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/i2si_bist_pattern_gen.sv
// Multi-channel BIST pattern source framing NUM_CH slots of SLOT_W serial clocks.
module i2si_bist_pattern_gen
  import i2si_bist_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int NUM_CH = 2,
  parameter int INC_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sck_transition,
  input  logic                          rf_bist_en,
  input  logic [1:0]                    rf_bist_mode,
  input  logic [DATA_W-1:0]             rf_bist_start_val,
  input  logic [DATA_W-1:0]             rf_bist_up_limit,
  input  logic [INC_W-1:0]              rf_bist_inc,
  output logic [DATA_W-1:0]             bist_out_data,
  output logic [ch_width(NUM_CH)-1:0]   bist_out_ch,
  output logic                          bist_out_xfc,
  output logic                          bist_active
);

  localparam int SLOT_CW = $clog2(SLOT_W);
  localparam int CH_W    = ch_width(NUM_CH);

  logic [SLOT_CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [CH_W-1:0]    ch_idx_q, ch_idx_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               dir_q, dir_d;
  logic [INC_W-1:0]   hold_q, hold_d;
  bist_mode_t         mode_q, mode_d;
  logic               active_q, active_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CH_W-1:0]    och_q, och_d;
  logic               xfc_q, xfc_d;

  logic               slot_last, ch_last, sb, fb;
  bist_mode_t         mode_in;
  logic [DATA_W-1:0]  wave_sample;
  logic               wave_dir;
  logic [INC_W-1:0]   wave_hold;

  assign mode_in   = bist_mode_t'(rf_bist_mode);
  assign slot_last = (slot_cnt_q == SLOT_CW'(SLOT_W-1));
  assign ch_last   = (ch_idx_q == CH_W'(NUM_CH-1));
  assign sb        = sck_transition && slot_last;
  assign fb        = sb && ch_last;

  i2si_bist_wave_core #(
    .DATA_W (DATA_W),
    .INC_W  (INC_W)
  ) u_wave (
    .mode_i   (mode_q),
    .sample_i (sample_q),
    .dir_i    (dir_q),
    .hold_i   (hold_q),
    .start_i  (rf_bist_start_val),
    .limit_i  (rf_bist_up_limit),
    .inc_i    (rf_bist_inc),
    .sample_o (wave_sample),
    .dir_o    (wave_dir),
    .hold_o   (wave_hold)
  );

  // Slot/channel framing, emission on slot boundaries, activation and update on frame boundaries
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    ch_idx_d   = ch_idx_q;
    sample_d   = sample_q;
    dir_d      = dir_q;
    hold_d     = hold_q;
    mode_d     = mode_q;
    active_d   = active_q;
    data_d     = data_q;
    och_d      = och_q;
    xfc_d      = 1'b0;

    if (sck_transition)
      slot_cnt_d = slot_last ? '0 : slot_cnt_q + SLOT_CW'(1);

    if (sb) begin
      ch_idx_d = ch_last ? '0 : ch_idx_q + CH_W'(1);
      if (active_q) begin
        data_d = sample_q + DATA_W'(ch_idx_q);
        och_d  = ch_idx_q;
        xfc_d  = 1'b1;
      end
    end

    if (fb) begin
      if (!active_q) begin
        // Activation boundary itself emits nothing
        if (rf_bist_en) begin
          active_d = 1'b1;
          sample_d = rf_bist_start_val;
          dir_d    = DIR_UP;
          hold_d   = '0;
          mode_d   = mode_in;
        end
      end else begin
        // A mode change restarts the pattern instead of stepping it
        if (mode_in != mode_q) begin
          mode_d   = mode_in;
          sample_d = rf_bist_start_val;
          dir_d    = DIR_UP;
          hold_d   = '0;
        end else begin
          sample_d = wave_sample;
          dir_d    = wave_dir;
          hold_d   = wave_hold;
        end
        if (!rf_bist_en)
          active_d = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= SLOT_CW'(SLOT_W-1);
      ch_idx_q   <= CH_W'(NUM_CH-1);
      sample_q   <= '0;
      dir_q      <= DIR_UP;
      hold_q     <= '0;
      mode_q     <= BIST_SAW;
      active_q   <= 1'b0;
      data_q     <= '0;
      och_q      <= '0;
      xfc_q      <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      ch_idx_q   <= ch_idx_d;
      sample_q   <= sample_d;
      dir_q      <= dir_d;
      hold_q     <= hold_d;
      mode_q     <= mode_d;
      active_q   <= active_d;
      data_q     <= data_d;
      och_q      <= och_d;
      xfc_q      <= xfc_d;
    end
  end

  assign bist_out_data = data_q;
  assign bist_out_ch   = och_q;
  assign bist_out_xfc  = xfc_q;
  assign bist_active   = active_q;

endmodule
